// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: aligns on in_sync, gathers slots 0..2 in shadow
// registers and publishes a whole frame on f0..f3 when the slot-3 word arrives.
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] f0,
  output logic [WIDTH-1:0] f1,
  output logic [WIDTH-1:0] f2,
  output logic [WIDTH-1:0] f3,
  output logic             out_valid,
  output logic [1:0]       slot,
  output logic             err
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [1:0]       slot_reg;
  logic [1:0]       slot_next;
  logic [WIDTH-1:0] shadow_reg [3];
  logic [WIDTH-1:0] frame_reg  [4];
  logic             out_valid_reg;
  logic             err_reg;

  logic             store_en;
  logic [1:0]       store_idx;
  logic             load_frame;
  logic             set_err;

  // State and slot register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= HUNT;
      slot_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
    end
  end

  // Next-state logic; idle cycles leave alignment untouched
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    if (in_valid) begin
      unique case (state_reg)
        HUNT: begin
          if (in_sync) begin
            state_next = RUN;
            slot_next  = 2'd1;
          end
        end
        RUN: begin
          if (in_sync) begin
            slot_next = 2'd1;
          end else if (slot_reg == 2'd0) begin
            state_next = HUNT;
            slot_next  = 2'd0;
          end else begin
            slot_next = slot_reg + 2'd1;
          end
        end
        default: begin
          state_next = HUNT;
          slot_next  = 2'd0;
        end
      endcase
    end
  end

  // Datapath controls decoded from state, slot and the accepted word
  always_comb begin
    store_en   = 1'b0;
    store_idx  = 2'd0;
    load_frame = 1'b0;
    set_err    = 1'b0;
    if (in_valid) begin
      unique case (state_reg)
        HUNT: begin
          if (in_sync) begin
            store_en = 1'b1;
          end
        end
        RUN: begin
          if (in_sync) begin
            // A sync anywhere but slot 0 restarts the frame on this word
            store_en = 1'b1;
            set_err  = (slot_reg != 2'd0);
          end else if (slot_reg == 2'd0) begin
            set_err = 1'b1;
          end else if (slot_reg == 2'd3) begin
            load_frame = 1'b1;
          end else begin
            store_en  = 1'b1;
            store_idx = slot_reg;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        shadow_reg[i] <= '0;
      end
    end else if (store_en) begin
      for (int i = 0; i < 3; i++) begin
        if (store_idx == 2'(i)) begin
          shadow_reg[i] <= w;
        end
      end
    end
  end

  // Frame outputs change only on a completed frame, so they never look partial
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        frame_reg[i] <= '0;
      end
    end else if (load_frame) begin
      for (int i = 0; i < 3; i++) begin
        frame_reg[i] <= shadow_reg[i];
      end
      frame_reg[3] <= w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      out_valid_reg <= load_frame;
      if (set_err) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign f0        = frame_reg[0];
  assign f1        = frame_reg[1];
  assign f2        = frame_reg[2];
  assign f3        = frame_reg[3];
  assign out_valid = out_valid_reg;
  assign slot      = slot_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed frame scenarios plus random traffic, checked
// against a queue-based frame model.
module tb_tdm_demux4;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_sync;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] f0, f1, f2, f3;
  logic             out_valid;
  logic [1:0]       slot;
  logic             err;

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .w        (w),
    .f0       (f0),
    .f1       (f1),
    .f2       (f2),
    .f3       (f3),
    .out_valid(out_valid),
    .slot     (slot),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Reference model: an aligned flag plus the words gathered so far this frame
  bit               m_aligned;
  logic [WIDTH-1:0] m_frame[$];
  logic [WIDTH-1:0] m_f[4];
  bit               m_ov;
  bit               m_err;
  int               total;
  int               bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_aligned = 1'b0;
    m_frame.delete();
    for (int i = 0; i < 4; i++) m_f[i] = '0;
    m_ov  = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [WIDTH-1:0] d);
    m_ov = 1'b0;
    if (!v) return;
    if (!m_aligned) begin
      if (s) begin
        m_aligned = 1'b1;
        m_frame.delete();
        m_frame.push_back(d);
      end
    end else if (s) begin
      if (m_frame.size() != 0) m_err = 1'b1;
      m_frame.delete();
      m_frame.push_back(d);
    end else if (m_frame.size() == 0) begin
      m_err     = 1'b1;
      m_aligned = 1'b0;
    end else begin
      m_frame.push_back(d);
      if (m_frame.size() == 4) begin
        for (int i = 0; i < 4; i++) m_f[i] = m_frame[i];
        m_ov = 1'b1;
        m_frame.delete();
      end
    end
  endtask

  task automatic compare_all();
    int exp_slot;
    exp_slot = m_aligned ? m_frame.size() : 0;
    check("f0", 32'(f0), 32'(m_f[0]));
    check("f1", 32'(f1), 32'(m_f[1]));
    check("f2", 32'(f2), 32'(m_f[2]));
    check("f3", 32'(f3), 32'(m_f[3]));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("slot", 32'(slot), 32'(exp_slot));
    check("err", 32'(err), 32'(m_err));
  endtask

  // One clock: drive after negedge, model the posedge, compare on the next negedge
  task automatic cycle(input bit v, input bit s, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sync  = s;
    w        = d;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(v, s, d);
    @(negedge clk);
    $display("tx v=%0b s=%0b w=%02h -> f=%02h %02h %02h %02h ov=%0b slot=%0d err=%0b",
             v, s, d, f0, f1, f2, f3, out_valid, slot, err);
    compare_all();
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  // Reset pulse strictly between clock edges
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_f0", 32'(f0), 32'h0);
    check("async_f3", 32'(f3), 32'h0);
    check("async_slot", 32'(slot), 32'h0);
    check("async_err", 32'(err), 32'h0);
    #1 rst = 1'b0;
  endtask

  task automatic frame(input logic [WIDTH-1:0] a, b, c, d, input int gap);
    cycle(1'b1, 1'b1, a);
    repeat (gap) cycle(1'b0, 1'b0, 8'hEE);
    cycle(1'b1, 1'b0, b);
    repeat (gap) cycle(1'b0, 1'b0, 8'hEE);
    cycle(1'b1, 1'b0, c);
    repeat (gap) cycle(1'b0, 1'b0, 8'hEE);
    cycle(1'b1, 1'b0, d);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    w        = '0;
    model_reset();
    @(negedge clk);
    // Valid sync word presented while reset is held must be ignored
    cycle(1'b1, 1'b1, 8'h55);
    check("rst_hold_slot", 32'(slot), 32'h0);
    rst = 1'b0;

    // Single frame
    frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
    check("frame1_f0", 32'(f0), 32'h11);
    check("frame1_f3", 32'(f3), 32'h44);
    check("frame1_ov", 32'(out_valid), 32'h1);
    cycle(1'b0, 1'b0, '0);
    check("frame1_ov_drop", 32'(out_valid), 32'h0);

    // Back-to-back frames
    frame(8'hA0, 8'hA1, 8'hA2, 8'hA3, 0);
    cycle(1'b1, 1'b1, 8'hB0);
    cycle(1'b1, 1'b0, 8'hB1);
    cycle(1'b1, 1'b0, 8'hB2);
    check("b2b_hold_f0", 32'(f0), 32'hA0);
    cycle(1'b1, 1'b0, 8'hB3);
    check("b2b_f0", 32'(f0), 32'hB0);
    check("b2b_ov", 32'(out_valid), 32'h1);

    // Gapped frame
    frame(8'h51, 8'h52, 8'h53, 8'h54, 3);
    check("gap_f2", 32'(f2), 32'h53);

    // Unsynced words in HUNT are dropped
    sync_reset();
    cycle(1'b1, 1'b0, 8'hAA);
    cycle(1'b1, 1'b0, 8'hBB);
    check("hunt_slot", 32'(slot), 32'h0);
    check("hunt_err", 32'(err), 32'h0);
    frame(8'h61, 8'h62, 8'h63, 8'h64, 0);
    check("hunt_f1", 32'(f1), 32'h62);

    // Early sync at slot 2
    cycle(1'b1, 1'b1, 8'h70);
    cycle(1'b1, 1'b0, 8'h01);
    cycle(1'b1, 1'b1, 8'h72);
    check("early_err", 32'(err), 32'h1);
    check("early_keep_f0", 32'(f0), 32'h61);
    cycle(1'b1, 1'b0, 8'h73);
    cycle(1'b1, 1'b0, 8'h74);
    cycle(1'b1, 1'b0, 8'h75);
    check("early_f0", 32'(f0), 32'h72);
    check("early_err_sticky", 32'(err), 32'h1);

    // Asynchronous reset mid-frame
    cycle(1'b1, 1'b1, 8'h81);
    cycle(1'b1, 1'b0, 8'h82);
    cycle(1'b1, 1'b0, 8'h83);
    async_reset();
    cycle(1'b1, 1'b0, 8'h84);
    frame(8'h91, 8'h92, 8'h93, 8'h94, 0);
    check("post_rst_f3", 32'(f3), 32'h94);
    check("post_rst_err", 32'(err), 32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 6) == 0),
            WIDTH'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
